// File: rtl/mod_counter_seq_pkg.sv
// ============================================================================
// Module  : mod_counter_seq_pkg
// Brief   : Shared state encoding and default sizes for the modulo-N run
//           controller and its counter datapath.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mod_counter_seq_pkg;

  localparam int DEF_MOD  = 6;
  localparam int DEF_CYCW = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mod_counter.sv
// ============================================================================
// Module  : mod_counter
// Brief   : Modulo-MOD counter datapath with enable, synchronous clear and a
//           registered wrap pulse aligned with the MOD-1 -> 0 step.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_counter
  import mod_counter_seq_pkg::*;
#(
  parameter  int MOD = DEF_MOD,
  localparam int CW  = $clog2(MOD)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          wrap
);

  logic [CW-1:0] r_count;
  logic          r_wrap;
  logic          w_last;

  assign w_last = (r_count == CW'(MOD - 1));

  // Clear wins over enable so an abort never produces a wrap pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= en & ~clr & w_last;
      if (clr) begin
        r_count <= '0;
      end else if (en) begin
        r_count <= w_last ? '0 : r_count + CW'(1);
      end
    end
  end

  assign count = r_count;
  assign wrap  = r_wrap;

endmodule

`default_nettype wire

// File: rtl/mod_counter_seq.sv
// ============================================================================
// Module  : mod_counter_seq
// Brief   : Run controller sequencing mod_counter through N full wraps, with
//           stop/abort and optional pause (MOD_COUNTER_SEQ_PAUSE_EN).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mod_counter_seq
  import mod_counter_seq_pkg::*;
#(
  parameter  int MOD  = DEF_MOD,
  parameter  int CYCW = DEF_CYCW,
  localparam int CW   = $clog2(MOD)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            pause,
  input  logic            stop,
  input  logic [CYCW-1:0] num_wraps,
  output logic [CW-1:0]   count,
  output logic            wrap,
  output logic [CYCW-1:0] wraps_done,
  output logic            busy,
  output logic            done
);

  state_t          r_state;
  state_t          w_next;
  logic [CYCW-1:0] r_target;
  logic [CYCW-1:0] r_wraps_done;
  logic            w_en;
  logic            w_clr;
  logic            w_last;
  logic            w_hold;
  logic            w_accept;

`ifdef MOD_COUNTER_SEQ_PAUSE_EN
  assign w_hold = pause;
`else
  // The pause port is kept for pin compatibility but has no effect.
  assign w_hold = pause & 1'b0;
`endif

  assign w_last   = (count == CW'(MOD - 1));
  assign w_accept = (r_state == S_IDLE) && start;

  always_comb begin
    w_next = r_state;
    w_en   = 1'b0;
    w_clr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_clr = 1'b1;
        if (start) begin
          w_next = (num_wraps != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (stop) begin
          w_clr  = 1'b1;
          w_next = S_IDLE;
        end else if (w_hold) begin
`ifdef MOD_COUNTER_SEQ_PAUSE_EN
          w_next = S_PAUSE;
`endif
        end else begin
          w_en = 1'b1;
          if (w_last && ((r_wraps_done + CYCW'(1)) == r_target)) begin
            w_next = S_DONE;
          end
        end
      end
`ifdef MOD_COUNTER_SEQ_PAUSE_EN
      S_PAUSE: begin
        if (stop) begin
          w_clr  = 1'b1;
          w_next = S_IDLE;
        end else if (!pause) begin
          w_next = S_RUN;
        end
      end
`endif
      S_DONE: begin
        w_clr  = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_clr  = 1'b1;
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_target     <= '0;
      r_wraps_done <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_wraps_done <= '0;
        if (num_wraps != '0) begin
          r_target <= num_wraps;
        end
      end else if (w_en && w_last) begin
        r_wraps_done <= r_wraps_done + CYCW'(1);
      end
    end
  end

  mod_counter #(
    .MOD (MOD)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .en    (w_en),
    .clr   (w_clr),
    .count (count),
    .wrap  (wrap)
  );

  assign wraps_done = r_wraps_done;
  assign busy       = (r_state == S_RUN) || (r_state == S_PAUSE);
  assign done       = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_mod_counter_seq.sv
// ============================================================================
// Module  : tb_mod_counter_seq
// Brief   : Directed, scoreboard-checked bench for mod_counter_seq (MOD=6).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mod_counter_seq;

  localparam int MOD  = 6;
  localparam int CYCW = 8;
  localparam int CW   = 3;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

`ifdef MOD_COUNTER_SEQ_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            pause;
  logic            stop;
  logic [CYCW-1:0] num_wraps;
  logic [CW-1:0]   count;
  logic            wrap;
  logic [CYCW-1:0] wraps_done;
  logic            busy;
  logic            done;

  mod_counter_seq #(
    .MOD  (MOD),
    .CYCW (CYCW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pause      (pause),
    .stop       (stop),
    .num_wraps  (num_wraps),
    .count      (count),
    .wrap       (wrap),
    .wraps_done (wraps_done),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit wrp;
    int wd;
    bit bsy;
    bit dn;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;
  int n_done_seen = 0;

  // Reference model state
  int m_st  = M_IDLE;
  int m_cnt = 0;
  int m_tgt = 0;
  int m_wd  = 0;
  bit m_wrp = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (!reset) begin
      m_st = M_IDLE; m_cnt = 0; m_tgt = 0; m_wd = 0; m_wrp = 1'b0;
      return;
    end
    m_wrp = 1'b0;
    case (m_st)
      M_IDLE: begin
        m_cnt = 0;
        if (start) begin
          m_wd = 0;
          if (num_wraps != 0) begin
            m_tgt = int'(num_wraps);
            m_st  = M_RUN;
          end else begin
            m_st = M_DONE;
          end
        end
      end
      M_RUN: begin
        if (stop) begin
          m_st = M_IDLE; m_cnt = 0;
        end else if (PAUSE_EN && pause) begin
          m_st = M_PAUSE;
        end else if (m_cnt == MOD - 1) begin
          m_cnt = 0; m_wd++; m_wrp = 1'b1;
          if (m_wd == m_tgt) m_st = M_DONE;
        end else begin
          m_cnt++;
        end
      end
      M_PAUSE: begin
        if (stop) begin
          m_st = M_IDLE; m_cnt = 0;
        end else if (!pause) begin
          m_st = M_RUN;
        end
      end
      default: begin
        m_cnt = 0;
        m_st  = M_IDLE;
      end
    endcase
  endtask

  // Push the expectation for the coming edge, clock it, then pop and compare.
  task automatic step();
    exp_t e;
    model_edge();
    e.cnt = m_cnt;
    e.wrp = m_wrp;
    e.wd  = m_wd;
    e.bsy = (m_st == M_RUN) || (m_st == M_PAUSE);
    e.dn  = (m_st == M_DONE);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("count", 32'(count), 32'(e.cnt));
    chk("wrap", 32'(wrap), 32'(e.wrp));
    chk("wraps_done", 32'(wraps_done), 32'(e.wd));
    chk("busy", 32'(busy), 32'(e.bsy));
    chk("done", 32'(done), 32'(e.dn));
    if (done) n_done_seen++;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0; num_wraps = 8'd2;
    #2;

    // 1: reset held low while start toggles
    for (int i = 0; i < 3; i++) begin
      start = ~start;
      step();
    end
    reset = 1'b1;
    start = 1'b0;

    // 2: basic run of two wraps; start on first edge with reset released
    start = 1'b1; num_wraps = 8'd2;
    step();
    start = 1'b0; num_wraps = 8'd7;
    n_done_seen = 0;
    for (int i = 0; i < 11; i++) step();
    start = 1'b1;
    step();
    chk("t2_done_pulses", 32'(n_done_seen), 32'd1);
    chk("t2_wraps_done", 32'(wraps_done), 32'd2);

    // 3: start ignored in DONE, then accepted back-to-back; pause at count 3
    num_wraps = 8'd2;
    step();
    step();
    start = 1'b0;
    for (int k = 0; k < 20 && m_cnt != 3; k++) step();
    pause = 1'b1;
    for (int i = 0; i < 4; i++) step();
    pause = 1'b0;
    for (int k = 0; k < 40 && m_st != M_IDLE; k++) step();
    step();

    // 4: stop at count 4 in the second period
    start = 1'b1; num_wraps = 8'd3;
    step();
    start = 1'b0;
    n_done_seen = 0;
    for (int k = 0; k < 40 && !(m_wd == 1 && m_cnt == 4); k++) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
    step();
    chk("t4_done_pulses", 32'(n_done_seen), 32'd0);
    chk("t4_wraps_done", 32'(wraps_done), 32'd1);

    // 5: zero request goes straight to DONE
    start = 1'b1; num_wraps = 8'd0;
    step();
    start = 1'b0;
    step();
    step();

    // 6: ignored start during RUN, then asynchronous reset at count 2
    start = 1'b1; num_wraps = 8'd3;
    step();
    start = 1'b0;
    step();
    start = 1'b1; num_wraps = 8'd1;
    step();
    start = 1'b0;
    chk("t6_pre_reset_count", 32'(count), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    chk("async_count", 32'(count), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_wraps_done", 32'(wraps_done), 32'd0);
    chk("async_wrap", 32'(wrap), 32'd0);
    chk("async_done", 32'(done), 32'd0);
    step();
    reset = 1'b1;
    start = 1'b1; num_wraps = 8'd1;
    step();
    start = 1'b0;
    n_done_seen = 0;
    for (int i = 0; i < 6; i++) step();
    chk("t6_done_at_6", 32'(done), 32'd1);
    step();
    step();
    chk("t6_done_pulses", 32'(n_done_seen), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
